// File: rtl/serial_pe_pkg.sv
// Shared types and constants for the serial PE sequencer and its result FIFO.
package serial_pe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [1:0] PE_CTL_FIRST = 2'b01;
   localparam logic [1:0] PE_CTL_LAST  = 2'b10;

   localparam int DATA_W = 16;
   localparam int RES_W  = 32;

endpackage

// File: rtl/serial_pe_res_fifo.sv
// Two-entry result FIFO; entry 0 is always the head, so a pop shifts entry 1 down.
// Push on full is never attempted because the sequencer meters last-element issue.
module serial_pe_res_fifo
   import serial_pe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [RES_W-1:0] push_data,
   input  logic             pop,
   output logic [RES_W-1:0] head_data,
   output logic             valid,
   output logic [1:0]       count
);

   logic [RES_W-1:0] ent0_q, ent0_d;
   logic [RES_W-1:0] ent1_q, ent1_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             do_pop;
   logic [1:0]       slot;

   assign do_pop = pop && (cnt_q != 2'd0);
   assign slot   = cnt_q - {1'b0, do_pop};

   // Next entry contents and occupancy; a simultaneous push lands behind the shifted head.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      if (do_pop) begin
         ent0_d = ent1_q;
      end
      if (push) begin
         if (slot == 2'd0) begin
            ent0_d = push_data;
         end else begin
            ent1_d = push_data;
         end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head_data = ent0_q;
   assign valid     = (cnt_q != 2'd0);
   assign count     = cnt_q;

endmodule

// File: rtl/serial_pe_ctrl.sv
// Sequencer streaming neuron/weight pairs into one serial PE and collecting its sums.
// Build option: SERIAL_PE_CTRL_RELU_EN clamps negative sums to zero before the FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a job, start_ready high
// ST_RUN   | issuing buffer reads, one element per cycle unless out of credits
// ST_DRAIN | all reads issued, waiting for in-flight sums and FIFO to empty
// ST_DONE  | job finished, done pulses on the way back to idle
module serial_pe_ctrl
   import serial_pe_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              start_ready,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic [LEN_W-1:0]  num_out,
   input  logic [ADDR_W-1:0] n_base,
   input  logic [ADDR_W-1:0] w_base,
   output logic              nbuf_en,
   output logic              wbuf_en,
   output logic [ADDR_W-1:0] nbuf_addr,
   output logic [ADDR_W-1:0] wbuf_addr,
   input  logic [15:0]       nbuf_rdata,
   input  logic [15:0]       wbuf_rdata,
   output logic [15:0]       pe_neuron,
   output logic [15:0]       pe_weight,
   output logic [1:0]        pe_ctl,
   output logic              pe_vld,
   input  logic [31:0]       pe_result,
   input  logic              pe_vld_o,
   output logic [31:0]       res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  vec_len_q, vec_len_d;
   logic [LEN_W-1:0]  num_out_q, num_out_d;
   logic [ADDR_W-1:0] n_base_q, n_base_d;
   logic [LEN_W-1:0]  elem_q, elem_d;
   logic [LEN_W-1:0]  out_q, out_d;
   logic [ADDR_W-1:0] n_ptr_q, n_ptr_d;
   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [1:0]        infl_q, infl_d;
   logic              vld_q, vld_d;
   logic [1:0]        ctl_q, ctl_d;
   logic              done_q, done_d;

   logic              is_first, is_last, issue_ok, rd_en;
   logic [1:0]        fifo_cnt;
   logic [2:0]        credits;
   logic [RES_W-1:0]  push_data;

   assign is_first = (elem_q == '0);
   assign is_last  = (elem_q == vec_len_q - LEN_ONE);
   assign credits  = {1'b0, fifo_cnt} + {1'b0, infl_q};
   // Only a last element creates a future FIFO entry, so only it has to wait for a slot.
   assign issue_ok = !(is_last && (credits >= 3'd2));
   assign rd_en    = (state_q == ST_RUN) && issue_ok;

`ifdef SERIAL_PE_CTRL_RELU_EN
   assign push_data = pe_result[RES_W-1] ? '0 : pe_result;
`else
   assign push_data = pe_result;
`endif

   // Next-state, pointer, credit and tag-pipeline computation.
   always_comb begin
      state_d   = state_q;
      vec_len_d = vec_len_q;
      num_out_d = num_out_q;
      n_base_d  = n_base_q;
      elem_d    = elem_q;
      out_d     = out_q;
      n_ptr_d   = n_ptr_q;
      w_ptr_d   = w_ptr_q;
      done_d    = 1'b0;
      vld_d     = rd_en;
      ctl_d     = rd_en ? ({is_last, 1'b0} | {1'b0, is_first}) : 2'b00;
      infl_d    = infl_q + {1'b0, rd_en && is_last} - {1'b0, pe_vld_o};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               vec_len_d = vec_len;
               num_out_d = num_out;
               n_base_d  = n_base;
               elem_d    = '0;
               out_d     = '0;
               n_ptr_d   = n_base;
               w_ptr_d   = w_base;
               state_d   = ((vec_len == '0) || (num_out == '0)) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_en) begin
               // Weights are laid out back to back per output, so that pointer never rewinds.
               w_ptr_d = w_ptr_q + ADDR_ONE;
               if (is_last) begin
                  elem_d  = '0;
                  n_ptr_d = n_base_q;
                  out_d   = out_q + LEN_ONE;
                  if (out_q == num_out_q - LEN_ONE) begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  elem_d  = elem_q + LEN_ONE;
                  n_ptr_d = n_ptr_q + ADDR_ONE;
               end
            end
         end
         ST_DRAIN: begin
            if ((infl_q == 2'd0) && (fifo_cnt == 2'd0)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller state, job parameters, pointers and registered PE tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         vec_len_q <= '0;
         num_out_q <= '0;
         n_base_q  <= '0;
         elem_q    <= '0;
         out_q     <= '0;
         n_ptr_q   <= '0;
         w_ptr_q   <= '0;
         infl_q    <= 2'd0;
         vld_q     <= 1'b0;
         ctl_q     <= 2'b00;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_len_q <= vec_len_d;
         num_out_q <= num_out_d;
         n_base_q  <= n_base_d;
         elem_q    <= elem_d;
         out_q     <= out_d;
         n_ptr_q   <= n_ptr_d;
         w_ptr_q   <= w_ptr_d;
         infl_q    <= infl_d;
         vld_q     <= vld_d;
         ctl_q     <= ctl_d;
         done_q    <= done_d;
      end
   end

   serial_pe_res_fifo u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pe_vld_o),
      .push_data (push_data),
      .pop       (res_ready),
      .head_data (res_data),
      .valid     (res_valid),
      .count     (fifo_cnt)
   );

   assign start_ready = (state_q == ST_IDLE);
   assign nbuf_en     = rd_en;
   assign wbuf_en     = rd_en;
   assign nbuf_addr   = n_ptr_q;
   assign wbuf_addr   = w_ptr_q;
   assign pe_neuron   = nbuf_rdata;
   assign pe_weight   = wbuf_rdata;
   assign pe_vld      = vld_q;
   assign pe_ctl      = ctl_q;
   assign done        = done_q;

endmodule

// File: tb/tb_serial_pe_ctrl.sv
// Bench for serial_pe_ctrl: SRAM and PE behavioural models around the DUT, expected
// address/tag/result streams computed per job from the dot-product definition.
module tb_serial_pe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start_ready;
   logic [9:0]  vec_len = '0, num_out = '0, n_base = '0, w_base = '0;
   logic        nbuf_en, wbuf_en;
   logic [9:0]  nbuf_addr, wbuf_addr;
   logic [15:0] nbuf_rdata = '0, wbuf_rdata = '0;
   logic [15:0] pe_neuron, pe_weight;
   logic [1:0]  pe_ctl;
   logic        pe_vld;
   logic [31:0] pe_result;
   logic        pe_vld_o;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        done;

   serial_pe_ctrl #(.ADDR_W(10), .LEN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
      .vec_len(vec_len), .num_out(num_out), .n_base(n_base), .w_base(w_base),
      .nbuf_en(nbuf_en), .wbuf_en(wbuf_en), .nbuf_addr(nbuf_addr), .wbuf_addr(wbuf_addr),
      .nbuf_rdata(nbuf_rdata), .wbuf_rdata(wbuf_rdata),
      .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
      .pe_result(pe_result), .pe_vld_o(pe_vld_o),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // buffer SRAMs with one-cycle read latency
   logic [15:0] nmem [1024];
   logic [15:0] wmem [1024];
   always @(posedge clk) begin
      if (nbuf_en) nbuf_rdata <= nmem[nbuf_addr];
      if (wbuf_en) wbuf_rdata <= wmem[wbuf_addr];
   end

   // PE model: signed MAC, first restarts, last raises vld_o one cycle later
   logic signed [31:0] pe_acc, pe_prod, pe_nxt;
   assign pe_prod = $signed(pe_neuron) * $signed(pe_weight);
   assign pe_nxt  = pe_ctl[0] ? pe_prod : pe_acc + pe_prod;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_acc <= '0; pe_result <= '0; pe_vld_o <= 1'b0;
      end else begin
         if (pe_vld) begin
            pe_acc    <= pe_nxt;
            pe_result <= pe_nxt;
         end
         pe_vld_o <= pe_ctl[1];
      end
   end

   int rdy_mode = 0;
   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
         endcase
      end
   end

   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [19:0] exp_addr_q [$];
   logic [1:0]  exp_ctl_q [$];
   logic [31:0] exp_res_q [$];
   int rd_cnt, pop_cnt, done_cnt, done_cyc, acc_cyc;
   int first_rd, first_vld, first_vldo, first_resv;
   logic [31:0] got_first, got_last;

   // monitor: compare every read, tag and popped result with the expected streams
   always @(negedge clk) begin
      if (rst_n) begin
         chk("en_equal", wbuf_en, nbuf_en);
         if (nbuf_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rd_addr", {nbuf_addr, wbuf_addr}, exp_addr_q.pop_front());
         end
         if (pe_vld) begin
            if (first_vld < 0) first_vld = cyc;
            if (exp_ctl_q.size() == 0) chk("unexpected_pe_vld", 1, 0);
            else chk("pe_ctl", pe_ctl, exp_ctl_q.pop_front());
         end else begin
            chk("pe_ctl_idle", pe_ctl, 2'b00);
         end
         if (pe_vld_o && first_vldo < 0) first_vldo = cyc;
         if (res_valid && first_resv < 0) first_resv = cyc;
         if (res_valid && res_ready) begin
            pop_cnt++;
            if (pop_cnt == 1) got_first = res_data;
            got_last = res_data;
            if (exp_res_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("res_data", res_data, exp_res_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic launch_job(input int vl, input int no, input int nb, input int wb);
      int sum;
      logic signed [15:0] a, b;
      exp_addr_q.delete(); exp_ctl_q.delete(); exp_res_q.delete();
      if (vl > 0) begin
         for (int o = 0; o < no; o++) begin
            sum = 0;
            for (int e = 0; e < vl; e++) begin
               a = nmem[(nb + e) % 1024];
               b = wmem[(wb + o * vl + e) % 1024];
               sum = sum + a * b;
               exp_addr_q.push_back({10'((nb + e) % 1024), 10'((wb + o * vl + e) % 1024)});
               exp_ctl_q.push_back({e == vl - 1, e == 0});
            end
`ifdef SERIAL_PE_CTRL_RELU_EN
            if (sum < 0) sum = 0;
`endif
            exp_res_q.push_back(32'(sum));
         end
      end
      rd_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
      first_rd = -1; first_vld = -1; first_vldo = -1; first_resv = -1;
      got_first = '0; got_last = '0;
      @(posedge clk); #1;
      chk("start_ready_idle", start_ready, 1);
      vec_len = 10'(vl); num_out = 10'(no); n_base = 10'(nb); w_base = 10'(wb);
      start = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      start = 1'b0;
      vec_len = 10'($urandom); num_out = 10'($urandom);
      n_base = 10'($urandom); w_base = 10'($urandom);
   endtask

   task automatic finish_job(input int no, input int bound);
      for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
      chk("done_timeout", done_cnt != 0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", done_cnt, 1);
      chk("result_count", pop_cnt, no);
      chk("reads_left", exp_addr_q.size(), 0);
      chk("start_ready_end", start_ready, 1);
      chk("res_valid_end", res_valid, 0);
   endtask

   typedef struct {
      int vl, no, nb, wb, mode, has_exp;
      logic [31:0] exp_first, exp_last;
   } vec_t;
   vec_t tbl [6];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         nmem[i] = 16'($urandom);
         wmem[i] = 16'($urandom);
      end
      nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3;
      wmem[100] = 16'd4; wmem[101] = 16'd5; wmem[102] = 16'd6;
      nmem[10] = 16'd7; wmem[200] = 16'd3; wmem[201] = 16'hFFFE;

      tbl[0] = '{3, 1, 0, 100, 0, 1, 32'd32, 32'd32};
`ifdef SERIAL_PE_CTRL_RELU_EN
      tbl[1] = '{1, 2, 10, 200, 0, 1, 32'd21, 32'd0};
`else
      tbl[1] = '{1, 2, 10, 200, 0, 1, 32'd21, 32'hFFFF_FFF2};
`endif
      tbl[2] = '{0, 3, 40, 50, 0, 0, 32'd0, 32'd0};
      tbl[3] = '{4, 0, 40, 50, 0, 0, 32'd0, 32'd0};
      tbl[4] = '{4, 1, 300, 1022, 1, 0, 32'd0, 32'd0};
      tbl[5] = '{5, 3, 500, 600, 1, 0, 32'd0, 32'd0};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_en", {nbuf_en, wbuf_en}, 0);
      chk("rst_addr", {nbuf_addr, wbuf_addr}, 0);
      chk("rst_pe", {pe_vld, pe_ctl, pe_neuron, pe_weight}, 0);
      chk("rst_res", {res_valid, res_data}, 0);
      chk("rst_done", done, 0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         rdy_mode = tbl[i].mode;
         launch_job(tbl[i].vl, tbl[i].no, tbl[i].nb, tbl[i].wb);
         finish_job((tbl[i].vl == 0) ? 0 : tbl[i].no, 300);
         if (tbl[i].has_exp != 0) begin
            chk("tbl_first", got_first, tbl[i].exp_first);
            chk("tbl_last", got_last, tbl[i].exp_last);
         end
         if (tbl[i].vl == 0 || tbl[i].no == 0) begin
            chk("zero_no_reads", rd_cnt, 0);
            chk("zero_no_res_valid", first_resv, -1);
            chk("zero_done_time", done_cyc, acc_cyc + 1);
         end
         if (i == 0) begin
            chk("lat_first_read", first_rd, acc_cyc);
            chk("lat_pe_vld", first_vld, acc_cyc + 1);
            chk("lat_pe_vld_o", first_vldo, acc_cyc + tbl[i].vl + 1);
            chk("lat_res_valid", first_resv, acc_cyc + tbl[i].vl + 2);
         end
      end

      // backpressure: ready held low, issue must stop at the third last element
      rdy_mode = 2;
      launch_job(2, 4, 700, 710);
      repeat (10) @(posedge clk);
      #1;
      chk("bp_reads_stalled", rd_cnt, 5);
      chk("bp_no_pops", pop_cnt, 0);
      chk("bp_start_ready_busy", start_ready, 0);
      vec_len = 10'd1; num_out = 10'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rdy_mode = 0;
      finish_job(4, 300);

      // reset in the middle of a run
      rdy_mode = 0;
      launch_job(6, 3, 20, 30);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_start_ready", start_ready, 1);
      chk("midrst_en", {nbuf_en, wbuf_en}, 0);
      chk("midrst_addr", {nbuf_addr, wbuf_addr}, 0);
      chk("midrst_pe", {pe_vld, pe_ctl}, 0);
      chk("midrst_res_done", {res_valid, done}, 0);
      exp_addr_q.delete(); exp_ctl_q.delete(); exp_res_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt, 0);
      launch_job(3, 2, 900, 950);
      finish_job(2, 300);

      // randomized jobs
      for (int j = 0; j < 20; j++) begin
         int vl, no;
         for (int i = 0; i < 1024; i++) begin
            nmem[i] = 16'($urandom);
            wmem[i] = 16'($urandom);
         end
         vl = $urandom_range(1, 8);
         no = $urandom_range(1, 5);
         rdy_mode = $urandom_range(0, 1);
         launch_job(vl, no, $urandom_range(0, 1023), $urandom_range(0, 1023));
         finish_job(no, 600);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
